// File: rtl/read_burst_master.sv
// read_burst_master: Avalon-MM burst read master feeding a downstream FIFO.
// Issues fixed-length read bursts from iRead_Addr up to iRead_Addr+iLength,
// waiting for FIFO room before each burst and forwarding every returned
// beat to the FIFO one cycle later.
// Optional feature: define READ_BURST_TIMEOUT_EN to add oTimeout and abort a
// burst whose data stops arriving for 4096 cycles.
module read_burst_master #(
  parameter int BURST_LEN  = 8,
  parameter int FIFO_DEPTH = 256
) (
  input  logic        iClk,
  input  logic        iRst_n,
  input  logic        iStart,
  input  logic [31:0] iRead_Addr,
  input  logic [31:0] iLength,
  input  logic        iWait,
  input  logic [31:0] iReadData,
  input  logic        iReadDataValid,
  input  logic [7:0]  FF_used,
  output logic [31:0] oRead_Addr,
  output logic        oRead,
  output logic [9:0]  oBurst_count,
  output logic        FF_wr_req,
  output logic [31:0] FF_wr_data,
  output logic        oDone
`ifdef READ_BURST_TIMEOUT_EN
  ,
  output logic        oTimeout
`endif
);

  localparam logic [31:0] BURST_BYTES = 32'(BURST_LEN * 4);
  localparam logic [10:0] DEPTH_W     = 11'(FIFO_DEPTH);
  localparam logic [10:0] BURST_W     = 11'(BURST_LEN);

  typedef enum logic [2:0] {IDLE, CHECK, REQ, DATA, NEXT} state_t;

  state_t      state, state_nxt;
  logic [31:0] end_addr;
  logic [31:0] next_addr;
  logic [9:0]  beat_cnt;
  logic [10:0] ff_free;
  logic        room;
  logic        last_beat;
  logic        done_addr;
  logic        to_hit;

  assign oBurst_count = 10'(BURST_LEN);
  assign oRead        = (state == REQ);
  assign next_addr    = oRead_Addr + BURST_BYTES;   // wraps modulo 2^32
  assign done_addr    = (next_addr >= end_addr);
  assign last_beat    = iReadDataValid && (beat_cnt == 10'(BURST_LEN - 1));

  // Free FIFO space, clamped at zero so an over-reported fill level never wraps
  assign ff_free = (11'(FF_used) >= DEPTH_W) ? 11'd0 : (DEPTH_W - 11'(FF_used));
  assign room    = (ff_free >= BURST_W);

`ifdef READ_BURST_TIMEOUT_EN
  logic [15:0] to_cnt;
  assign to_hit = (to_cnt == 16'd4095) && !iReadDataValid;

  // Idle-cycle counter for the data phase; any beat or leaving DATA restarts it
  always_ff @(posedge iClk) begin
    if (!iRst_n || state != DATA || iReadDataValid) to_cnt <= '0;
    else                                            to_cnt <= to_cnt + 16'd1;
  end
`else
  assign to_hit = 1'b0;
`endif

  // State register
  always_ff @(posedge iClk) begin
    if (!iRst_n) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (iStart && iLength != 32'd0) state_nxt = CHECK;
      CHECK:   if (room)                       state_nxt = REQ;
      REQ:     if (!iWait)                     state_nxt = DATA;
      DATA: begin
        if (last_beat)   state_nxt = NEXT;
        else if (to_hit) state_nxt = IDLE;
      end
      NEXT:    state_nxt = done_addr ? IDLE : CHECK;
      default: state_nxt = IDLE;
    endcase
  end

  // Address, end address and completion flags
  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      oRead_Addr <= '0;
      end_addr   <= '0;
      oDone      <= 1'b0;
`ifdef READ_BURST_TIMEOUT_EN
      oTimeout   <= 1'b0;
`endif
    end else begin
      if (state == IDLE && iStart) begin
        oRead_Addr <= iRead_Addr;
        end_addr   <= iRead_Addr + iLength;
        oDone      <= (iLength == 32'd0);   // empty transfer completes at once
`ifdef READ_BURST_TIMEOUT_EN
        oTimeout   <= 1'b0;
`endif
      end
      if (state == NEXT) begin
        oRead_Addr <= next_addr;
        if (done_addr) oDone <= 1'b1;
      end
`ifdef READ_BURST_TIMEOUT_EN
      if (state == DATA && !last_beat && to_hit) begin
        oDone    <= 1'b1;
        oTimeout <= 1'b1;
      end
`endif
    end
  end

  // Beat counter: only beats inside DATA count toward the burst
  always_ff @(posedge iClk) begin
    if (!iRst_n || state != DATA) beat_cnt <= '0;
    else if (iReadDataValid)      beat_cnt <= last_beat ? 10'd0 : beat_cnt + 10'd1;
  end

  // FIFO write path: each DATA beat becomes one write, one cycle later
  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      FF_wr_req  <= 1'b0;
      FF_wr_data <= '0;
    end else begin
      FF_wr_req <= (state == DATA) && iReadDataValid;
      if (state == DATA && iReadDataValid) FF_wr_data <= iReadData;
    end
  end

endmodule

// File: tb/tb_read_burst_master.sv
// Directed bench for read_burst_master (BURST_LEN=8, FIFO_DEPTH=256).
module tb_read_burst_master;

  logic        iClk = 1'b0;
  logic        iRst_n, iStart, iWait, iReadDataValid;
  logic [31:0] iRead_Addr, iLength, iReadData;
  logic [7:0]  FF_used;
  logic [31:0] oRead_Addr, FF_wr_data;
  logic        oRead, FF_wr_req, oDone;
  logic [9:0]  oBurst_count;
`ifdef READ_BURST_TIMEOUT_EN
  logic        oTimeout;
`endif

  int checks = 0;
  int fails  = 0;
  logic [31:0] wq[$];

  read_burst_master #(.BURST_LEN(8), .FIFO_DEPTH(256)) dut (
    .iClk(iClk), .iRst_n(iRst_n), .iStart(iStart), .iRead_Addr(iRead_Addr),
    .iLength(iLength), .iWait(iWait), .iReadData(iReadData),
    .iReadDataValid(iReadDataValid), .FF_used(FF_used),
    .oRead_Addr(oRead_Addr), .oRead(oRead), .oBurst_count(oBurst_count),
    .FF_wr_req(FF_wr_req), .FF_wr_data(FF_wr_data), .oDone(oDone)
`ifdef READ_BURST_TIMEOUT_EN
    , .oTimeout(oTimeout)
`endif
  );

  always #5 iClk = ~iClk;

  // FIFO-side capture of every write
  always @(negedge iClk) if (FF_wr_req === 1'b1) wq.push_back(FF_wr_data);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge iClk);
    #1;
  endtask

  task automatic start(input logic [31:0] a, input logic [31:0] len);
    iRead_Addr = a; iLength = len; iStart = 1'b1;
    tick();
    iStart = 1'b0;
  endtask

  // Acts as the Avalon slave for one burst
  task automatic serve(input logic [31:0] exp_addr, input logic [31:0] d0,
                       input int nbeats, input int waitc);
    int n = 0;
    iWait = (waitc > 0);
    while (oRead !== 1'b1 && n < 50) begin tick(); n++; end
    chk("read_req", {31'd0, oRead}, 32'd1);
    chk("req_addr", oRead_Addr, exp_addr);
    for (int k = 0; k < waitc; k++) begin
      iStart = 1'b1; iRead_Addr = 32'hDEAD0000; iLength = 32'd64;  // must be ignored
      tick();
      chk("wait_read", {31'd0, oRead}, 32'd1);
      chk("wait_addr", oRead_Addr, exp_addr);
    end
    iStart = 1'b0; iWait = 1'b0;
    tick();
    chk("read_drop", {31'd0, oRead}, 32'd0);
    for (int i = 0; i < nbeats; i++) begin
      iReadDataValid = 1'b1; iReadData = d0 + 32'(i);
      tick();
    end
    iReadDataValid = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (oDone !== 1'b1 && n < 50) begin tick(); n++; end
    chk("done", {31'd0, oDone}, 32'd1);
  endtask

  task automatic check_writes(input int first, input logic [31:0] d0, input int cnt);
    chk("wr_count", 32'(wq.size()), 32'(first + cnt));
    for (int i = 0; i < cnt; i++)
      if (first + i < wq.size()) chk("wr_data", wq[first + i], d0 + 32'(i));
  endtask

  initial begin
    int q0;
    iRst_n = 1'b0; iStart = 1'b0; iRead_Addr = '0; iLength = '0; iWait = 1'b0;
    iReadData = '0; iReadDataValid = 1'b0; FF_used = '0;
    tick(); tick();
    chk("rst_read",  {31'd0, oRead}, 32'd0);
    chk("rst_addr",  oRead_Addr, 32'd0);
    chk("rst_wrreq", {31'd0, FF_wr_req}, 32'd0);
    chk("rst_wrdat", FF_wr_data, 32'd0);
    chk("rst_done",  {31'd0, oDone}, 32'd0);
    chk("bcount",    {22'd0, oBurst_count}, 32'd8);
    iRst_n = 1'b1;
    tick();

    // Single burst
    q0 = wq.size();
    start(32'h1000, 32'd32);
    chk("start_done_clr", {31'd0, oDone}, 32'd0);
    serve(32'h1000, 32'hA000, 8, 0);
    wait_done();
    chk("end_addr1", oRead_Addr, 32'h1020);
    tick(); tick(); tick();
    chk("done_hold", {31'd0, oDone}, 32'd1);
    check_writes(q0, 32'hA000, 8);

    // Three bursts
    q0 = wq.size();
    start(32'h1000, 32'd96);
    chk("done_clr3", {31'd0, oDone}, 32'd0);
    serve(32'h1000, 32'hB000, 8, 0);
    serve(32'h1020, 32'hB008, 8, 0);
    chk("mid_done", {31'd0, oDone}, 32'd0);
    serve(32'h1040, 32'hB010, 8, 0);
    wait_done();
    chk("end_addr3", oRead_Addr, 32'h1060);
    tick();
    check_writes(q0, 32'hB000, 24);

    // FIFO backpressure: 6 free words < 8, then exactly 8 free
    FF_used = 8'd250;
    start(32'h3000, 32'd32);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("ff_hold", {31'd0, oRead}, 32'd0);
    end
    FF_used = 8'd248;
    tick();
    chk("ff_go", {31'd0, oRead}, 32'd1);
    FF_used = 8'd0;
    serve(32'h3000, 32'hC000, 8, 0);
    wait_done();

    // Waitrequest held 5 cycles, stray iStart ignored
    q0 = wq.size();
    start(32'h5000, 32'd32);
    serve(32'h5000, 32'hD000, 8, 5);
    wait_done();
    chk("wait_end_addr", oRead_Addr, 32'h5020);
    tick();
    check_writes(q0, 32'hD000, 8);

    // Address wrap: end address wraps to 0
    start(32'hFFFF_FFE0, 32'd32);
    serve(32'hFFFF_FFE0, 32'hE000, 8, 0);
    wait_done();
    chk("wrap_addr", oRead_Addr, 32'h0);

    // Zero length: done next cycle, no read
    start(32'h6000, 32'd0);
    chk("zero_done", {31'd0, oDone}, 32'd1);
    tick(); tick();
    chk("zero_noread", {31'd0, oRead}, 32'd0);

    // Reset after 3 of 8 beats
    q0 = wq.size();
    start(32'h2000, 32'd32);
    serve(32'h2000, 32'hF000, 3, 0);
    iRst_n = 1'b0;
    tick();
    chk("mr_wrreq", {31'd0, FF_wr_req}, 32'd0);
    chk("mr_wrdat", FF_wr_data, 32'd0);
    chk("mr_addr",  oRead_Addr, 32'd0);
    chk("mr_read",  {31'd0, oRead}, 32'd0);
    chk("mr_done",  {31'd0, oDone}, 32'd0);
    iRst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      iReadDataValid = 1'b1; iReadData = 32'h5A5A0000 + 32'(i);
      tick();
    end
    iReadDataValid = 1'b0;
    tick(); tick();
    chk("mr_nowrite", 32'(wq.size()), 32'(q0 + 3));
    chk("mr_noread", {31'd0, oRead}, 32'd0);

`ifdef READ_BURST_TIMEOUT_EN
    begin
      int n = 0;
      start(32'h4000, 32'd32);
      chk("to_clr", {31'd0, oTimeout}, 32'd0);
      serve(32'h4000, 32'h7000, 7, 0);
      while (oDone !== 1'b1 && n < 5000) begin tick(); n++; end
      chk("to_done", {31'd0, oDone}, 32'd1);
      chk("to_flag", {31'd0, oTimeout}, 32'd1);
      chk("to_late", {31'd0, n >= 4090}, 32'd1);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
